// File: rtl/video_fill_dma.sv
// video_fill_dma: rectangle-fill engine for the 80x60 framebuffer.
// A 3-word iomem slave window (CTRL/RECT/COLOR) programs the fill; an
// iomem-style master then issues one 32-bit write per pixel of the clipped
// rectangle into the selected framebuffer segment.
//
// state | meaning
// IDLE  | waiting for a start write; done holds the last completion status
// CLIP  | one cycle: clip the rectangle against the screen, seed counters
// RUN   | fb_valid high, one beat per fb_ready until the rectangle is filled
module video_fill_dma #(
  parameter logic [31:0] REG_BASE = 32'h3000_0030,
  parameter logic [31:0] FB_ADDR0 = 32'h1000_0000,
  parameter logic [31:0] FB_ADDR1 = 32'h1000_8000,
  parameter int          XRES     = 80,
  parameter int          YRES     = 60
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        fill_sel,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [31:0] fb_addr,
  output logic [31:0] fb_wdata,
  output logic [3:0]  fb_wstrb,
  output logic        busy
);

  localparam logic [7:0]  L_XRES   = 8'(XRES);
  localparam logic [6:0]  L_YRES   = 7'(YRES);
  localparam logic [15:0] L_STRIDE = 16'(XRES * 4);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_RUN} state_t;

  state_t      r_state;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [6:0]  r_x0;
  logic [5:0]  r_y0;
  logic [6:0]  r_w;
  logic [5:0]  r_h;
  logic [23:0] r_color;
  logic        r_seg;
  logic        r_done;
  logic        r_abort_pend;
  logic [6:0]  r_x;
  logic [5:0]  r_y;
  logic [7:0]  r_x_end;
  logic [6:0]  r_y_end;
  logic [31:0] r_row_base;
  logic        r_fb_valid;
  logic [31:0] r_fb_addr;
  logic [31:0] r_fb_wdata;

  logic        w_sel_ctrl, w_sel_rect, w_sel_color;
  logic        w_hit, w_wr, w_busy, w_start, w_abort;
  logic [31:0] w_rd_data;
  logic [7:0]  w_x_sum, w_x_end;
  logic [6:0]  w_y_sum, w_y_end;
  logic        w_empty;
  logic [31:0] w_seg_base, w_row_start, w_next_row;
  logic [15:0] w_row_off;
  logic [6:0]  w_x_next;
  logic [5:0]  w_y_next;
  logic        w_unused;

  assign w_sel_ctrl  = (iomem_addr == REG_BASE);
  assign w_sel_rect  = (iomem_addr == REG_BASE + 32'd4);
  assign w_sel_color = (iomem_addr == REG_BASE + 32'd8);
  // Blocking on r_ready makes the acknowledge a single-cycle pulse.
  assign w_hit   = !r_ready && iomem_valid && (w_sel_ctrl || w_sel_rect || w_sel_color);
  assign w_wr    = w_hit && (iomem_wstrb != 4'd0);
  assign w_busy  = (r_state != S_IDLE);
  // Abort in the same CTRL write suppresses start.
  assign w_start = w_wr && w_sel_ctrl && iomem_wdata[0] && !iomem_wdata[2] && !w_busy;
  assign w_abort = w_wr && w_sel_ctrl && iomem_wdata[2];

  assign w_x_sum     = {1'b0, r_x0} + {1'b0, r_w};
  assign w_x_end     = (w_x_sum > L_XRES) ? L_XRES : w_x_sum;
  assign w_y_sum     = {1'b0, r_y0} + {1'b0, r_h};
  assign w_y_end     = (w_y_sum > L_YRES) ? L_YRES : w_y_sum;
  assign w_empty     = (r_w == 7'd0) || (r_h == 6'd0) ||
                       ({1'b0, r_x0} >= L_XRES) || ({1'b0, r_y0} >= L_YRES);
  assign w_seg_base  = r_seg ? FB_ADDR1 : FB_ADDR0;
  assign w_row_off   = {10'd0, r_y0} * L_STRIDE;
  assign w_row_start = w_seg_base + {16'd0, w_row_off};
  assign w_next_row  = r_row_base + {16'd0, L_STRIDE};
  assign w_x_next    = r_x + 7'd1;
  assign w_y_next    = r_y + 6'd1;

  assign w_unused = &{1'b0, iomem_wdata[31:30], iomem_wdata[15:14], iomem_wdata[7]};

  // Read-back mux for the register window.
  always_comb begin
    w_rd_data = 32'd0;
    if (w_sel_ctrl)       w_rd_data = {29'd0, r_seg, r_done, w_busy};
    else if (w_sel_rect)  w_rd_data = {2'b0, r_h, 1'b0, r_w, 2'b0, r_y0, 1'b0, r_x0};
    else if (w_sel_color) w_rd_data = {8'd0, r_color};
  end

  // Slave side: registered acknowledge/read data, config writes only while idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_x0    <= 7'd0;
      r_y0    <= 6'd0;
      r_w     <= 7'd0;
      r_h     <= 6'd0;
      r_color <= 24'd0;
      r_seg   <= 1'b0;
    end else begin
      r_ready <= w_hit;
      r_rdata <= w_hit ? w_rd_data : 32'd0;
      if (w_wr && !w_busy) begin
        if (w_sel_ctrl) r_seg <= iomem_wdata[1];
        if (w_sel_rect) begin
          r_x0 <= iomem_wdata[6:0];
          r_y0 <= iomem_wdata[13:8];
          r_w  <= iomem_wdata[22:16];
          r_h  <= iomem_wdata[29:24];
        end
        if (w_sel_color) r_color <= iomem_wdata[23:0];
      end
    end
  end

  // Fill FSM: clip, then walk the rectangle row by row one beat per fb_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_x          <= 7'd0;
      r_y          <= 6'd0;
      r_x_end      <= 8'd0;
      r_y_end      <= 7'd0;
      r_row_base   <= 32'd0;
      r_fb_valid   <= 1'b0;
      r_fb_addr    <= 32'd0;
      r_fb_wdata   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_abort_pend <= 1'b0;
          if (w_start) begin
            r_done  <= 1'b0;
            r_state <= S_CLIP;
          end
        end
        S_CLIP: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_x        <= r_x0;
            r_y        <= r_y0;
            r_x_end    <= w_x_end;
            r_y_end    <= w_y_end;
            r_row_base <= w_row_start;
            r_fb_addr  <= w_row_start + {23'd0, r_x0, 2'b00};
            r_fb_wdata <= {8'd0, r_color};
            r_fb_valid <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_fb_valid && fb_ready) begin
            if (r_abort_pend || w_abort) begin
              r_fb_valid   <= 1'b0;
              r_abort_pend <= 1'b0;
              r_state      <= S_IDLE;
            end else if ({1'b0, w_x_next} < r_x_end) begin
              r_x       <= w_x_next;
              r_fb_addr <= r_fb_addr + 32'd4;
            end else if ({1'b0, w_y_next} < r_y_end) begin
              r_x        <= r_x0;
              r_y        <= w_y_next;
              r_row_base <= w_next_row;
              r_fb_addr  <= w_next_row + {23'd0, r_x0, 2'b00};
            end else begin
              r_fb_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else if (w_abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        default: begin
          r_fb_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign fill_sel    = w_hit;
  assign fb_valid    = r_fb_valid;
  assign fb_addr     = r_fb_addr;
  assign fb_wdata    = r_fb_wdata;
  assign fb_wstrb    = r_fb_valid ? 4'b1111 : 4'b0000;
  assign busy        = w_busy;

endmodule

// File: doc/video_fill_dma.md
Name: video_fill_dma

Overview:
Rectangle-fill engine upstream of the 80x60 framebuffer. The CPU programs a rectangle and a 24-bit colour through a small iomem slave window. The block then acts as an iomem-style bus master and issues one 32-bit write per pixel into the selected framebuffer segment (0 or 1). Its writes land in the framebuffer RAMs exactly as CPU writes do, which frees the CPU from per-pixel stores.

Parameters:
REG_BASE, 32'h30_000_030, base of the 3-word register window (CTRL +0, RECT +4, COLOR +8).
FB_ADDR0, 32'h10_000_000, byte address of framebuffer segment 0.
FB_ADDR1, 32'h10_000_000 + (8192*4), byte address of framebuffer segment 1.
XRES, 80, framebuffer width in pixels.
YRES, 60, framebuffer height in pixels.

Ports:
clk  in  1  system clock; sole clock.
resetn  in  1  asynchronous, active-low reset.
iomem_valid  in  1  slave request.
iomem_ready  out  1  slave acknowledge, registered.
iomem_wstrb  in  4  nonzero = write, zero = read.
iomem_addr  in  32  slave byte address.
iomem_wdata  in  32  slave write data.
iomem_rdata  out  32  slave read data; 0 when not selected.
fill_sel  out  1  high while a request hits this block's window (for the bus rdata/ready mux).
fb_valid  out  1  master write request.
fb_ready  in  1  master acknowledge from the framebuffer path.
fb_addr  out  32  master byte address.
fb_wdata  out  32  {8'h00, colour[23:0]}.
fb_wstrb  out  4  4'b1111 whenever fb_valid is high, else 0.
busy  out  1  fill in progress.

Behaviour:
- Reset (async, resetn=0): iomem_ready=0, iomem_rdata=0, fb_valid=0, fb_addr=0, fb_wdata=0, busy=0, done=0, all registers 0, FSM=IDLE. Reset mid-fill drops fb_valid immediately; the current beat is lost.
- Slave select: hit = !iomem_ready && iomem_valid && addr in {REG_BASE, +4, +8}. fill_sel = hit. iomem_ready <= hit; this gives a 1-cycle pulse, and the slave is never ready on two consecutive cycles.
- Register writes take effect on the hit cycle:
  - CTRL write: bit0 = start, bit1 = segment, bit2 = abort.
  - RECT: x0=[6:0], y0=[13:8], w=[22:16], h=[29:24].
  - COLOR: [23:0].
- While busy, writes to RECT, COLOR, segment and start are acknowledged but ignored. Only abort acts while busy.
- Read data (registered alongside iomem_ready):
  - CTRL reads {29'b0, segment, done, busy}.
  - RECT and COLOR read back their stored value.
- FSM states:
  - IDLE: a start write while idle clears done and goes to CLIP.
  - CLIP, 1 cycle:
    - x_end = min(x0+w, XRES); y_end = min(y0+h, YRES).
    - If w==0 or h==0 or x0>=XRES or y0>=YRES, set done=1 and return to IDLE with zero writes.
    - Otherwise x=x0, y=y0, row_base = seg_base + y0*XRES*4, and go to RUN.
  - RUN:
    - fb_valid=1, fb_addr = row_base + x*4.
    - addr, wdata and valid hold stable until fb_ready.
    - On fb_valid && fb_ready:
      - If x+1 < x_end: x++.
      - Else if y+1 < y_end: x=x0, y++, row_base += XRES*4.
      - Else: fb_valid=0, done=1, go to IDLE.
    - fb_valid drops for at least 1 cycle between beats only at completion; back-to-back beats are allowed.
- busy = (state != IDLE).
- Abort:
  - When fb_valid is low: return to IDLE immediately.
  - When fb_valid is high: latch an abort-pending flag, finish the outstanding beat on fb_ready, then return to IDLE.
  - done stays 0 on abort.
- Simultaneous start and abort in one CTRL write while idle: abort wins and no fill starts.
- Latency: start write on cycle N → CLIP at N+1 → first fb_valid at N+2.
- A fill with no back-pressure takes w'*h' beats, where w' and h' are the clipped width and height.
- Arithmetic: y0*XRES*4 uses 16-bit intermediates. Addresses never exceed seg_base + XRES*YRES*4 - 4.
- The block does not arbitrate with the CPU; the integrator's bus mux grants fb_*.

Test Plan:
1. Reset, then read CTRL → 0x0. Read COLOR → 0x0. fb_valid stays 0 for 100 cycles.
2. COLOR=0x00FF8000, RECT x0=2,y0=3,w=3,h=2, CTRL=0x1 with fb_ready tied 1 → 6 writes to 0x100003C8, 0x100003CC, 0x100003D0, 0x10000508, 0x1000050C, 0x10000510, each with wdata 0x00FF8000. Then busy=0, CTRL reads 0x2.
3. Segment 1 with x0=78,y0=59,w=10,h=10 → clipped to 2 writes: 0x10008000+0x4AF8 and 0x10008000+0x4AFC. Then done=1.
4. w=0 → CTRL reads 0x2 two cycles after start, no fb_valid. x0=80 → same result.
5. fb_ready random 30% duty → fb_addr and fb_wdata are stable while fb_valid && !fb_ready. The full 4x4 fill produces 16 unique addresses in order.
6. Abort issued while fb_valid is high and fb_ready is held low 5 cycles → fb_valid holds until the ready beat, then IDLE with done=0. A RECT write during busy leaves RECT unchanged. resetn pulsed low mid-fill → fb_valid drops in the same cycle.
